crc_frame_encoder: RTL and testbench
====================================

# crc_frame_encoder

Frame source for the CRC link: accepts 10-bit message words over a valid/ready handshake and computes each word's 4-bit CRC serially. It buffers one complete frame, then emits it on `dataout` as a gap-free burst of tagged 16-bit words. Sits directly upstream of the CRC checker/RAM writer, which starts writing on tag `01`, writes one word per clock and stops on tag `11`.

## Interface
- `MESS_LEN`, 10, message bits per word
- `CRC_LEN`, 4, CRC bits per word
- `POLY`, 5'b10011, generator polynomial x^4+x+1, MSB = x^4
- `DEPTH`, 16, maximum words per frame, power of two, ≤ 32
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  message word offered
- `in_ready`  out  1  block can accept a word this cycle
- `in_data`  in  MESS_LEN  message word, MSB first in CRC order
- `in_last`  in  1  qualifies `in_data` as the final word of the frame
- `sink_idle`  in  1  downstream is waiting for a start tag; sampled only in WAIT_SINK
- `dataout`  out  MESS_LEN+CRC_LEN+2  {tag[1:0], msg, crc}; all zero when not bursting
- `busy`  out  1  high in every state except IDLE
- `overflow`  out  1  one-cycle pulse, frame force-closed at DEPTH words

## Operation
- Tags: `00` idle, `01` first word, `10` middle word, `11` last word.
- States:
  - IDLE: `in_ready`=1. A handshake (`in_valid`&`in_ready`) latches the word and `in_last`, clears the CRC register and goes to ENC.
  - ENC: MESS_LEN cycles. Each cycle shifts one message bit, MSB first: fb = crc[3]^bit; crc = {crc[2:0],0} ^ (fb ? POLY[3:0] : 0).
  - STORE: 1 cycle. Writes {msg, crc} to `buf[wr_ptr]` and increments `wr_ptr`. Next state is WAIT_SINK if the word was last or `wr_ptr` reaches DEPTH; otherwise IDLE.
  - WAIT_SINK: waits for `sink_idle`=1, then goes to BURST with `rd_ptr`=0.
  - BURST: emits one word per clock. Tag is `01` on `rd_ptr`=0, `11` on `rd_ptr`=count-1, `10` otherwise. Goes to GAP after the last word.
  - GAP: 1 cycle with `dataout`=0, clears the pointers, then returns to IDLE.
- Resulting CRC equals the remainder of msg·x^4 mod POLY, so the downstream division of the 14-bit codeword leaves a zero remainder.
- Single-word frame (count=1): emitted as the word tagged `01`, followed by an appended all-zero word {`11`, 0, 0000]. The downstream check always sees a start word and a distinct end word.
- Overflow: if STORE fills word DEPTH without `in_last`, the frame is closed as if `in_last` were set. `overflow` pulses in the STORE cycle. The next input word starts a new frame.
- `in_last` is sampled only on a handshake.
- `in_data` changes outside a handshake are ignored.

## Timing
- Reset values: `in_ready`=0 while `rst` is high, then 1 in IDLE. `dataout`=0, `busy`=0, `overflow`=0. State is IDLE, pointers are 0, the buffer is don't-care.
- Per-word intake: handshake cycle + MESS_LEN + 1 = 12 cycles between successive acceptances. `in_ready` is low for 11 cycles after each handshake.
- Last handshake to first burst word: 12 cycles, plus 1 cycle in WAIT_SINK when `sink_idle` is already high.
- Burst length is count cycles (2 for a single-word frame). There are no bubbles, and `dataout` is registered.
- `sink_idle` dropping during BURST is ignored; the burst completes.
- Reset asserted mid-frame or mid-burst: outputs return to reset values immediately and asynchronously. The partial frame is discarded and nothing resumes.
- `in_valid` and `in_last` asserted together in IDLE with count=0 produce a single-word frame.

## Structure
- Package `crc_frame_pkg` holds:
  - tag constants `TAG_IDLE/FIRST/MID/LAST`
  - the state enum
  - default `POLY`
  - `WORD_W` = MESS_LEN+CRC_LEN+2
- Sub-module `crc_serial`: a bit-serial CRC register with `clr` and `shift_en`, data bit in, CRC_LEN remainder out. It is reused by future checkers.
- Buffer: DEPTH×(MESS_LEN+CRC_LEN) register array; `wr_ptr` and `rd_ptr` are clog2(DEPTH)+1 bits wide.

## Test plan
- One frame of 3 words, each msg 10'b1101011011 with `sink_idle`=1 → `dataout` is `0x75BE`, `0xB5BE`, `0xF5BE` on consecutive clocks, then `0x0000`.
- Single word msg 0, `in_last`=1 → `dataout` is `0x4000` then `0xC000`; first word appears 13 cycles after the handshake.
- `in_valid` held high with 16 words and `in_last` never set → `overflow` pulses once, followed by a 16-word burst tagged `01`, `10`×14, `11`.
- Frame stored with `sink_idle`=0 for 20 cycles → `dataout` stays 0 and `in_ready` stays 0; burst starts 1 cycle after `sink_idle` rises.
- `rst` pulsed on the 2nd burst word → `dataout`=0 in the same cycle, `busy`=0; a following fresh frame is emitted correctly.
- Random 200 messages → every emitted 14-bit codeword divided by 10011 leaves a zero remainder.

Source files
------------

// File: rtl/crc_frame_pkg.sv
// Shared constants and types for the CRC frame source and its companion checkers.
package crc_frame_pkg;

  localparam int unsigned MESS_LEN_DEFAULT = 10;
  localparam int unsigned CRC_LEN_DEFAULT  = 4;
  localparam int unsigned WORD_W           = MESS_LEN_DEFAULT + CRC_LEN_DEFAULT + 2;

  // Generator x^4+x+1, MSB is the x^4 term
  localparam logic [4:0] POLY_DEFAULT = 5'b10011;

  localparam logic [1:0] TAG_IDLE  = 2'b00;
  localparam logic [1:0] TAG_FIRST = 2'b01;
  localparam logic [1:0] TAG_MID   = 2'b10;
  localparam logic [1:0] TAG_LAST  = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StEnc,
    StStore,
    StWaitSink,
    StBurst,
    StGap
  } state_e;

endpackage

// File: rtl/crc_serial.sv
// Bit-serial CRC register: one data bit per enabled clock, MSB of the message first.
module crc_serial
  import crc_frame_pkg::*;
#(
  parameter int unsigned        CRC_LEN = 4,
  parameter logic [CRC_LEN:0]   POLY    = POLY_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift_en,
  input  logic               din,
  output logic [CRC_LEN-1:0] crc
);

  logic [CRC_LEN-1:0] crc_q;
  logic               fb;

  assign fb  = crc_q[CRC_LEN-1] ^ din;
  assign crc = crc_q;

  // Remainder register; clear wins over shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= '0;
    end else if (clr) begin
      crc_q <= '0;
    end else if (shift_en) begin
      crc_q <= {crc_q[CRC_LEN-2:0], 1'b0} ^ (fb ? POLY[CRC_LEN-1:0] : '0);
    end
  end

endmodule

// File: rtl/crc_frame_encoder.sv
// Collects message words, appends a serial CRC to each, buffers one frame and
// emits it as a gap-free tagged burst once the downstream sink is idle.
module crc_frame_encoder
  import crc_frame_pkg::*;
#(
  parameter int unsigned      MESS_LEN = 10,
  parameter int unsigned      CRC_LEN  = 4,
  parameter logic [CRC_LEN:0] POLY     = POLY_DEFAULT,
  parameter int unsigned      DEPTH    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [MESS_LEN-1:0]          in_data,
  input  logic                         in_last,
  input  logic                         sink_idle,
  output logic [MESS_LEN+CRC_LEN+1:0]  dataout,
  output logic                         busy,
  output logic                         overflow
);

  localparam int unsigned CW = MESS_LEN + CRC_LEN;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned BW = $clog2(MESS_LEN);

  state_e              state_q, state_d;
  logic [MESS_LEN-1:0] msg_q, msg_d;
  logic                last_q, last_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW+1:0]       dataout_q, dataout_d;
  logic [CW-1:0]       mem_q [DEPTH];

  logic                crc_clr, crc_shift, mem_we;
  logic [CRC_LEN-1:0]  crc;
  logic [PW-1:0]       last_idx;
  logic [CW-1:0]       rd_word;

  crc_serial #(
    .CRC_LEN (CRC_LEN),
    .POLY    (POLY)
  ) u_crc (
    .clk      (clk),
    .rst      (rst),
    .clr      (crc_clr),
    .shift_en (crc_shift),
    .din      (msg_q[MESS_LEN-1]),
    .crc      (crc)
  );

  assign in_ready = (state_q == StIdle) & ~rst;
  assign busy     = (state_q != StIdle);
  assign overflow = (state_q == StStore) & ~last_q & (wr_ptr_q == PW'(DEPTH - 1));
  assign dataout  = dataout_q;

  // A one-word frame is padded with an all-zero end word so start and end tags differ
  assign last_idx = (wr_ptr_q == PW'(1)) ? PW'(1) : wr_ptr_q - PW'(1);
  assign rd_word  = (rd_ptr_q < wr_ptr_q) ? mem_q[rd_ptr_q[AW-1:0]] : '0;

  // Next-state, datapath updates and next burst word
  always_comb begin
    state_d   = state_q;
    msg_d     = msg_q;
    last_d    = last_q;
    bit_cnt_d = bit_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    dataout_d = '0;
    crc_clr   = 1'b0;
    crc_shift = 1'b0;
    mem_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          msg_d     = in_data;
          last_d    = in_last;
          bit_cnt_d = '0;
          crc_clr   = 1'b1;
          state_d   = StEnc;
        end
      end
      StEnc: begin
        crc_shift = 1'b1;
        // Rotate so the message is back in place after MESS_LEN shifts
        msg_d     = {msg_q[MESS_LEN-2:0], msg_q[MESS_LEN-1]};
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (bit_cnt_q == BW'(MESS_LEN - 1)) begin
          state_d = StStore;
        end
      end
      StStore: begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
        state_d  = (last_q || (wr_ptr_d == PW'(DEPTH))) ? StWaitSink : StIdle;
      end
      StWaitSink: begin
        if (sink_idle) begin
          dataout_d = {TAG_FIRST, mem_q[0]};
          rd_ptr_d  = PW'(1);
          state_d   = StBurst;
        end
      end
      StBurst: begin
        if (rd_ptr_q > last_idx) begin
          state_d = StGap;
        end else begin
          dataout_d = {(rd_ptr_q == last_idx) ? TAG_LAST : TAG_MID, rd_word};
          rd_ptr_d  = rd_ptr_q + PW'(1);
        end
      end
      StGap: begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      msg_q     <= '0;
      last_q    <= 1'b0;
      bit_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      dataout_q <= '0;
    end else begin
      state_q   <= state_d;
      msg_q     <= msg_d;
      last_q    <= last_d;
      bit_cnt_q <= bit_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      dataout_q <= dataout_d;
    end
  end

  // Frame buffer; contents are only read below wr_ptr so no reset is needed
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {msg_q, crc};
    end
  end

endmodule

// File: tb/tb_crc_frame_encoder.sv
// Directed bench for crc_frame_encoder with hand-computed burst words.
module tb_crc_frame_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        sink_idle = 1'b1;
  logic [9:0]  in_data = '0;
  logic        in_ready, busy, overflow;
  logic [15:0] dataout;

  int          n_cmp = 0;
  int          n_err = 0;
  int          ovf_cnt = 0;
  int          lat;
  logic [15:0] got [$];
  logic [9:0]  sent [$];

  crc_frame_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .sink_idle (sink_idle),
    .dataout   (dataout),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (overflow) ovf_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] gw(input int i);
    return (i < got.size()) ? got[i] : 16'hdead;
  endfunction

  // Plain long division of the 14-bit codeword by 10011
  function automatic logic [3:0] rem14(input logic [13:0] cw);
    logic [13:0] v;
    logic [13:0] p;
    v = cw;
    p = 14'b10011;
    for (int i = 13; i >= 4; i--) begin
      if (v[i]) v = v ^ (p << (i - 4));
    end
    return v[3:0];
  endfunction

  task automatic send_word(input logic [9:0] m, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = m;
    in_last  = l;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called in cycle 1 after a handshake; lat ends as the cycle of the first word
  task automatic collect(input int budget);
    got.delete();
    lat = 1;
    while (dataout == 16'h0 && lat < budget) begin
      @(posedge clk); #1;
      lat++;
    end
    while (dataout != 16'h0 && got.size() < 40) begin
      got.push_back(dataout);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int hi;
    int bad;
    int base;
    int n;
    logic [1:0] etag;

    // Reset values
    #2;
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_dataout", 32'(dataout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    #10 rst = 1'b0;
    @(posedge clk); #1;
    check("idle_ready", 32'(in_ready), 32'd1);

    // Three-word frame, ready low for 11 cycles after each handshake
    send_word(10'b1101011011, 1'b0);
    hi = 0;
    for (int i = 0; i < 11; i++) begin
      hi += int'(in_ready);
      @(posedge clk); #1;
    end
    check("ready_low_11", 32'(hi), 32'd0);
    check("ready_back", 32'(in_ready), 32'd1);
    send_word(10'b1101011011, 1'b0);
    send_word(10'b1101011011, 1'b1);
    collect(60);
    check("f3_lat", 32'(lat), 32'd13);
    check("f3_len", 32'(got.size()), 32'd3);
    check("f3_w0", 32'(gw(0)), 32'h75be);
    check("f3_w1", 32'(gw(1)), 32'hb5be);
    check("f3_w2", 32'(gw(2)), 32'hf5be);
    check("f3_gap", 32'(dataout), 32'h0);

    // Single word, msg 0
    send_word(10'h000, 1'b1);
    collect(60);
    check("s0_lat", 32'(lat), 32'd13);
    check("s0_len", 32'(got.size()), 32'd2);
    check("s0_w0", 32'(gw(0)), 32'h4000);
    check("s0_w1", 32'(gw(1)), 32'hc000);

    // Single word, all ones
    send_word(10'h3ff, 1'b1);
    collect(60);
    check("s1_len", 32'(got.size()), 32'd2);
    check("s1_w0", 32'(gw(0)), 32'h7ff6);
    check("s1_w1", 32'(gw(1)), 32'hc000);

    // Overflow: 16 words without in_last
    base = ovf_cnt;
    for (int i = 0; i < 16; i++) send_word(10'b1101011011, 1'b0);
    collect(60);
    check("ovf_pulses", 32'(ovf_cnt - base), 32'd1);
    check("ovf_len", 32'(got.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("ovf_w%0d", i), 32'(gw(i)),
            (i == 0) ? 32'h75be : (i == 15) ? 32'hf5be : 32'hb5be);
    end

    // Sink busy for 20 cycles holds the frame
    sink_idle = 1'b0;
    send_word(10'b1101011011, 1'b1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (dataout != 16'h0 || in_ready) bad++;
      @(posedge clk); #1;
    end
    check("hold_quiet", 32'(bad), 32'd0);
    sink_idle = 1'b1;
    @(posedge clk); #1;
    check("hold_release", 32'(dataout), 32'h75be);
    collect(5);
    check("hold_len", 32'(got.size()), 32'd2);
    check("hold_w1", 32'(gw(1)), 32'hc000);

    // Reset on the second burst word, then a fresh frame
    for (int i = 0; i < 3; i++) send_word(10'b1101011011, i == 2);
    n = 0;
    while (dataout == 16'h0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    check("rb_w1", 32'(dataout), 32'hb5be);
    rst = 1'b1;
    #1;
    check("rb_dataout", 32'(dataout), 32'h0);
    check("rb_busy", 32'(busy), 32'd0);
    check("rb_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rb_idle_ready", 32'(in_ready), 32'd1);
    send_word(10'h3ff, 1'b0);
    send_word(10'b1101011011, 1'b1);
    collect(60);
    check("rb_len", 32'(got.size()), 32'd2);
    check("rb_f_w0", 32'(gw(0)), 32'h7ff6);
    check("rb_f_w1", 32'(gw(1)), 32'hf5be);

    // 200 random messages in 25 frames of 8
    for (int f = 0; f < 25; f++) begin
      sent.delete();
      for (int i = 0; i < 8; i++) begin
        sent.push_back(10'($urandom_range(0, 1023)));
        send_word(sent[i], i == 7);
      end
      collect(60);
      check($sformatf("rnd%0d_len", f), 32'(got.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
        etag = (i == 0) ? 2'b01 : (i == 7) ? 2'b11 : 2'b10;
        check($sformatf("rnd%0d_rem%0d", f, i), 32'(rem14(gw(i) & 16'h3fff)), 32'd0);
        check($sformatf("rnd%0d_hdr%0d", f, i), 32'({gw(i) >> 4}),
              32'({etag, sent[i]}));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
